// File: rtl/vram_host_port.sv
// vram_host_port: bridges an asynchronous 8-bit host bus onto the VRAM host port.
// Provides an auto-incrementing pointer, write commits and a one-byte read-ahead.
module vram_host_port #(
    parameter int ADDR_WIDTH  = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  busCsN,
    input  logic                  busRdN,
    input  logic                  busWrN,
    input  logic [1:0]            busRs,
    input  logic [7:0]            busDataIn,
    output logic [7:0]            busDataOut,
    output logic                  busDataOe,
    output logic [ADDR_WIDTH-1:0] hostAddr,
    output logic [7:0]            hostWrData,
    output logic                  hostSelect,
    output logic                  hostRd,
    input  logic [7:0]            hostRdData
);

    localparam int HI_W = ADDR_WIDTH - 8;

    localparam logic [1:0] RS_ADDR_LO = 2'd0;
    localparam logic [1:0] RS_ADDR_HI = 2'd1;
    localparam logic [1:0] RS_DATA    = 2'd2;
    localparam logic [1:0] RS_CTRL    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        VWRITE,
        INC,
        VREAD,
        VCAPTURE
    } stateT;

    stateT state;
    stateT nextState;

    logic [SYNC_STAGES-1:0] csSync;
    logic [SYNC_STAGES-1:0] rdSync;
    logic [SYNC_STAGES-1:0] wrSync;

    logic csN;
    logic rdN;
    logic wrN;
    logic wrAct;
    logic rdAct;
    logic wrActQ;
    logic rdActQ;
    logic wrRise;
    logic wrFall;
    logic rdRise;
    logic rdFall;

    logic [1:0] wrRs;
    logic [7:0] wrData;
    logic [1:0] rdRs;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [7:0]            wrBuf;
    logic [7:0]            prefetch;
    logic                  autoInc;
    logic                  overrun;
    logic                  busy;

    logic wrNeedsFsm;
    logic rdNeedsFsm;
    logic wrGo;
    logic rdGo;
    logic drop;

    logic [7:0] hiPad;
    logic [7:0] readMux;

    // Bring the host strobes into the dot clock domain.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            csSync <= '1;
            rdSync <= '1;
            wrSync <= '1;
        end else begin
            csSync <= {csSync[SYNC_STAGES-2:0], busCsN};
            rdSync <= {rdSync[SYNC_STAGES-2:0], busRdN};
            wrSync <= {wrSync[SYNC_STAGES-2:0], busWrN};
        end
    end

    assign csN = csSync[SYNC_STAGES-1];
    assign rdN = rdSync[SYNC_STAGES-1];
    assign wrN = wrSync[SYNC_STAGES-1];

    // Both strobes low at once is treated as no access at all.
    assign wrAct = ~csN & ~wrN & rdN;
    assign rdAct = ~csN & ~rdN & wrN;

    // Delayed activity flags for edge detection.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wrActQ <= 1'b0;
            rdActQ <= 1'b0;
        end else begin
            wrActQ <= wrAct;
            rdActQ <= rdAct;
        end
    end

    assign wrRise = wrAct & ~wrActQ;
    assign wrFall = ~wrAct & wrActQ;
    assign rdRise = rdAct & ~rdActQ;
    assign rdFall = ~rdAct & rdActQ;

    // Capture register select and data once, when a strobe is first seen.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wrRs   <= 2'd0;
            wrData <= 8'd0;
            rdRs   <= 2'd0;
        end else begin
            if (wrRise) begin
                wrRs   <= busRs;
                wrData <= busDataIn;
            end
            if (rdRise) begin
                rdRs <= busRs;
            end
        end
    end

    assign busy = (state != IDLE);

    // A commit or read end that needs the sequencer is dropped while busy;
    // a simultaneous write wins over a DATA read end.
    assign wrNeedsFsm = wrFall & (wrRs != RS_CTRL);
    assign rdNeedsFsm = rdFall & (rdRs == RS_DATA);
    assign wrGo = wrNeedsFsm & ~busy;
    assign rdGo = rdNeedsFsm & ~busy & ~wrNeedsFsm;
    assign drop = (wrNeedsFsm & busy)
                | (rdNeedsFsm & (busy | wrNeedsFsm));

    // Host-visible register read mux.
    always_comb begin
        hiPad = 8'd0;
        hiPad[HI_W-1:0] = ptr[ADDR_WIDTH-1:8];
        readMux = 8'd0;
        unique case (busRs)
            RS_ADDR_LO: readMux = ptr[7:0];
            RS_ADDR_HI: readMux = hiPad;
            RS_DATA:    readMux = prefetch;
            RS_CTRL:    readMux = {5'd0, overrun, busy, autoInc};
            default:    readMux = 8'd0;
        endcase
    end

    // Pointer, write buffer, control and status registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ptr     <= '0;
            wrBuf   <= 8'd0;
            autoInc <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (wrGo && wrRs == RS_ADDR_LO) begin
                ptr[7:0] <= wrData;
            end else if (wrGo && wrRs == RS_ADDR_HI) begin
                ptr[ADDR_WIDTH-1:8] <= wrData[HI_W-1:0];
            end else if (state == INC && autoInc) begin
                ptr <= ptr + ADDR_WIDTH'(1);
            end
            if (wrGo && wrRs == RS_DATA) begin
                wrBuf <= wrData;
            end
            if (wrFall && wrRs == RS_CTRL) begin
                autoInc <= wrData[0];
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (rdFall && rdRs == RS_CTRL) begin
                overrun <= 1'b0;
            end
        end
    end

    // Read-ahead byte captured the cycle after a VRAM read.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            prefetch <= 8'd0;
        end else if (state == VCAPTURE) begin
            prefetch <= hostRdData;
        end
    end

    // Host read data and driver enable follow the read strobe.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            busDataOut <= 8'd0;
            busDataOe  <= 1'b0;
        end else if (rdRise) begin
            busDataOut <= readMux;
            busDataOe  <= 1'b1;
        end else if (rdFall) begin
            busDataOe <= 1'b0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Sequencer transitions and VRAM strobes.
    always_comb begin
        nextState  = state;
        hostSelect = 1'b0;
        hostRd     = 1'b1;
        unique case (state)
            IDLE: begin
                if (wrGo) begin
                    if (wrRs == RS_DATA) begin
                        nextState = VWRITE;
                    end else begin
                        nextState = VREAD;
                    end
                end else if (rdGo) begin
                    nextState = INC;
                end
            end
            VWRITE: begin
                hostSelect = 1'b1;
                hostRd     = 1'b0;
                nextState  = INC;
            end
            INC: begin
                nextState = VREAD;
            end
            VREAD: begin
                hostSelect = 1'b1;
                nextState  = VCAPTURE;
            end
            VCAPTURE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign hostAddr   = ptr;
    assign hostWrData = wrBuf;

endmodule

// File: doc/vram_host_port.md
Name: vram_host_port

Overview:
- Host-side writer/reader for the text-mode VRAM. It is the counterpart to the display readout path, which only reads VRAM.
- Takes an asynchronous 8-bit, 4-register host bus (microcontroller/6502 style) and synchronizes it to the dot clock.
- Drives the VRAM host port (hostAddr/hostWrData/hostSelect/hostRd/hostRdData): auto-incrementing address pointer, write commits, one-byte read-ahead buffer.
- Replaces the top level's tied-off host assignments.

Parameters:
ADDR_WIDTH, 13, VRAM address width; pointer wraps modulo 2^ADDR_WIDTH
SYNC_STAGES, 2, flip-flop stages on each asynchronous bus input strobe

Ports:
clk  in  1  dot clock (25.175 MHz), single clock domain
nrst  in  1  synchronous active-low reset, sampled on posedge clk
busCsN  in  1  async host chip select, active low
busRdN  in  1  async host read strobe, active low
busWrN  in  1  async host write strobe, active low
busRs  in  2  register select: 0 ADDR_LO, 1 ADDR_HI, 2 DATA, 3 CTRL/STATUS
busDataIn  in  8  host write data
busDataOut  out  8  host read data (registered)
busDataOe  out  1  enable for the external bus driver
hostAddr  out  ADDR_WIDTH  VRAM address; always equals the pointer register
hostWrData  out  8  VRAM write data
hostSelect  out  1  VRAM access strobe, one cycle per access
hostRd  out  1  1 = read, 0 = write; 1 when idle
hostRdData  in  8  VRAM read data, valid the cycle after hostSelect with hostRd=1

Behaviour:
- Clock and reset: one clock (clk); reset nrst is synchronous, active-low.
- Reset values: ptr=0, prefetch=0, autoInc=1, overrun=0, FSM=IDLE, hostSelect=0, hostRd=1, hostWrData=0, busDataOut=0, busDataOe=0. Synchronizer flops reset to the inactive level (1).
- Reset mid-operation: the FSM returns to IDLE with no further hostSelect. A strobe still low at reset release is treated as a new access.
- Synchronization: busCsN, busRdN and busWrN each pass through SYNC_STAGES flops.
  - wrAct = ~cs & ~wr & rd; rdAct = ~cs & ~rd & wr.
  - If rd and wr are both low, neither is active.
  - busRs and busDataIn are sampled unsynchronized, only on the edge-detect cycle; the host holds them stable for the whole strobe.
- Host timing contract: strobe low ≥4 clk, high ≥4 clk; read data valid 3 clk after the strobe falls.
- Write commit occurs on the wrAct falling edge (end of the strobe), cycle T:
  - ADDR_LO: ptr[7:0]<=data.
  - ADDR_HI: ptr[ADDR_WIDTH-1:8]<=data; unused bits are ignored.
  - CTRL: autoInc<=data[0].
  - DATA: wrBuf<=data.
  - ADDR_LO, ADDR_HI and DATA writes then start an FSM sequence at T+1. CTRL writes start no sequence.
- Read:
  - On the rdAct rising edge: busDataOut<=the mux value and busDataOe<=1.
  - Read mux: ADDR_LO → ptr[7:0]; ADDR_HI → upper ptr bits, zero-padded; DATA → prefetch; STATUS → {5'b0, overrun, busy, autoInc}.
  - On the rdAct falling edge: busDataOe<=0.
  - A DATA read end starts INC_PREFETCH. A STATUS read end clears overrun.
- FSM states: IDLE, VWRITE, INC, VREAD, VCAPTURE; busy = (state != IDLE).
  - DATA write: IDLE→VWRITE (hostSelect=1, hostRd=0, hostWrData=wrBuf) →INC→VREAD→VCAPTURE→IDLE.
  - DATA read end: IDLE→INC→VREAD→VCAPTURE→IDLE.
  - Address write: IDLE→VREAD→VCAPTURE→IDLE (prefetch only, no increment).
  - INC: ptr<=ptr+1 if autoInc, else unchanged. ptr wraps from 2^ADDR_WIDTH-1 to 0.
  - VREAD: hostSelect=1, hostRd=1 at the current ptr. VCAPTURE: prefetch<=hostRdData.
  - Latency: DATA write 4 clk busy; DATA read 3 clk; address write 2 clk.
- Overrun:
  - A commit or read end that needs the FSM while busy is dropped.
  - Its register side effects (ptr/wrBuf/ptr increment) are also dropped, and overrun<=1 (sticky).
  - CTRL writes and non-DATA reads while busy are still honoured.
  - A STATUS read end in the same cycle as an overrun event leaves overrun=1.
- hostSelect is never asserted for more than one consecutive cycle per access.

Test Plan:
- Reset, then read STATUS → 0x01; hostSelect stays 0, hostRd=1 throughout.
- Write ADDR_HI=0x12, ADDR_LO=0x34, DATA=0xA5 → one VRAM write at 0x1234 with data 0xA5. Then a prefetch read at 0x1235; ADDR_LO reads back 0x35.
- Preload VRAM 0x0000..0x0002 = 11,22,33; set ptr=0; three DATA reads → 0x11, 0x22, 0x33; final ptr=3.
- ptr=0x1FFF, DATA write 0x7E → write at 0x1FFF; ptr=0x0000; prefetch taken from address 0.
- CTRL=0x00; two DATA writes 0x01, 0x02 → both at the same address (last value 0x02); ptr unchanged.
- Second DATA write issued 2 clk after the first commit → dropped; STATUS read returns bit2=1; next STATUS read returns bit2=0.
